// File: rtl/pipe_stage_pkg.sv
// Shared pipeline encodings (NOP payload, stall/clear levels) and stage constants.
// Build option: PIPE_STAGE_SKID_EN selects the two-entry skid buffer instead of a single entry.
`ifndef PIPE_DEFINES_SVH
`define PIPE_DEFINES_SVH
`define NOP_PC     32'h0000_0000
`define NOP_INS    32'h0000_0013
`define ChipStall  1'b1
`define StageClear 1'b1
`endif

package pipe_stage_pkg;
   typedef logic [1:0] occ_t;
`ifdef PIPE_STAGE_SKID_EN
   localparam int unsigned BUF_DEPTH = 2;
`else
   localparam int unsigned BUF_DEPTH = 1;
`endif
endpackage

// File: rtl/pipe_stage_if.sv
// Upstream/downstream valid-ready handshake bundle for pipe_stage.
interface pipe_stage_if #(parameter int unsigned DATA_W = 64);
   logic              up_valid;
   logic              up_ready;
   logic [DATA_W-1:0] up_data;
   logic              dn_valid;
   logic              dn_ready;
   logic [DATA_W-1:0] dn_data;

   modport master (output up_valid, up_data, dn_ready,
                   input  up_ready, dn_valid, dn_data);
   modport slave  (input  up_valid, up_data, dn_ready,
                   output up_ready, dn_valid, dn_data);
endinterface

// File: rtl/pipe_skid_buf.sv
// FIFO storage for pipe_stage: DEPTH 1 or 2 entries with read/write pointers and a count.
module pipe_skid_buf
   import pipe_stage_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 1
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              clr,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] push_data,
   output logic [DATA_W-1:0] head_data,
   output occ_t              count
);
   logic [DATA_W-1:0] mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   occ_t              cnt_q;

   // a single-entry buffer keeps both pointers parked on slot 0
   function automatic logic ptr_inc(input logic p);
      return (DEPTH == 2) ? ~p : 1'b0;
   endfunction

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt_q  <= '0;
      end else if (clr) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt_q  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (push && !clr) mem[wr_ptr] <= push_data;
   end

   assign head_data = mem[rd_ptr];
   assign count     = cnt_q;
endmodule

// File: rtl/pipe_stage.sv
// Pipeline stage with stall/flush gating and a saturating downstream bubble counter.
// Build option: PIPE_STAGE_SKID_EN enables the two-entry skid buffer (up_ready from registered state only).
module pipe_stage
   import pipe_stage_pkg::*;
#(
   parameter int unsigned       DATA_W   = 64,
   parameter logic [DATA_W-1:0] NOP_DATA = {`NOP_PC, `NOP_INS},
   parameter int unsigned       CNT_W    = 16
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             stall,
   input  logic             flush,
   pipe_stage_if.slave      bus,
   output occ_t             occupancy,
   output logic [CNT_W-1:0] bubble_cnt
);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic              stall_act;
   logic              flush_act;
   logic              run_q;
   logic              push;
   logic              pop;
   logic              bubble;
   occ_t              cnt;
   logic [DATA_W-1:0] head;

   assign stall_act = (stall == `ChipStall);
   assign flush_act = (flush == `StageClear);

   // holds up_ready low through reset and releases it on the first edge afterwards
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) run_q <= 1'b0;
      else         run_q <= 1'b1;
   end

   assign bus.dn_valid = (cnt != 2'd0) && !stall_act;
   assign bus.dn_data  = bus.dn_valid ? head : NOP_DATA;

`ifdef PIPE_STAGE_SKID_EN
   assign bus.up_ready = run_q && !stall_act && (cnt != 2'd2);
   assign occupancy    = cnt;
`else
   assign bus.up_ready = run_q && !stall_act && ((cnt == 2'd0) || bus.dn_ready);
   assign occupancy    = {1'b0, cnt[0]};
`endif

   assign push   = bus.up_valid && bus.up_ready;
   assign pop    = bus.dn_valid && bus.dn_ready;
   assign bubble = bus.dn_ready && !bus.dn_valid && !stall_act && !flush_act;

   pipe_skid_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (BUF_DEPTH)
   ) u_buf (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .clr       (flush_act),
      .push      (push),
      .pop       (pop),
      .push_data (bus.up_data),
      .head_data (head),
      .count     (cnt)
   );

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)                          bubble_cnt <= '0;
      else if (bubble && bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + CNT_ONE;
   end
endmodule
